// File: rtl/cart_clk_supervisor_if.sv
// Status/control bundle between the cartridge PLL supervisor and its consumers.
// The supervisor side drives PLL reset and status and receives the raw PLL lock.
interface cart_clk_supervisor_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       domain_ready;
  logic       lock_fail;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  modport master (
    input  pll_locked,
    output pll_rst, domain_ready, lock_fail, retry_count, loss_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, domain_ready, lock_fail, retry_count, loss_count
  );
endinterface

// File: rtl/cart_clk_supervisor.sv
// Cartridge PLL supervisor: pulses PLL reset, qualifies the synchronized lock,
// retries on timeout, and reports lock failure and lock-loss events.
module cart_clk_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 742500,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int LOSS_FILTER   = 4
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  cart_clk_supervisor_if.master sup
);

  // One counter serves both the reset pulse and the lock timeout.
  localparam int TMR_W_RAW = ($clog2(LOCK_TIMEOUT) > $clog2(RST_CYCLES)) ?
                             $clog2(LOCK_TIMEOUT) : $clog2(RST_CYCLES);
  localparam int TMR_W  = (TMR_W_RAW < 1) ? 1 : TMR_W_RAW;
  localparam int STB_W  = $clog2(STABLE_CYCLES + 1);
  localparam int LOSS_W = $clog2(LOSS_FILTER + 1);

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [STB_W-1:0]  stable_q, stable_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [3:0]        retry_q, retry_d;
  logic [7:0]        loss_cnt_q, loss_cnt_d;
  logic              pll_rst_q, pll_rst_d;
  logic              domain_ready_q, domain_ready_d;
  logic              lock_fail_q, lock_fail_d;
  logic              locked_s;
  logic              stable_reach;
  logic              loss_reach;

  assign locked_s     = sync_q[1];
  assign stable_reach = (32'(stable_q) + 32'd1) >= 32'(STABLE_CYCLES);
  assign loss_reach   = (32'(loss_q) + 32'd1) >= 32'(LOSS_FILTER);

  always_comb begin
    sync_d     = {sync_q[0], sup.pll_locked};
    state_d    = state_q;
    tmr_d      = tmr_q;
    stable_d   = stable_q;
    loss_d     = loss_q;
    retry_d    = retry_q;
    loss_cnt_d = loss_cnt_q;

    unique case (state_q)
      S_RESET_PLL: begin
        if (tmr_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock is checked before the timeout so a lock on the last cycle wins.
        if (locked_s) begin
          state_d  = S_STABILIZE;
          stable_d = STB_W'(1);
        end else if (tmr_q == TMO_LAST) begin
          tmr_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = S_RESET_PLL;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_STABILIZE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else if (stable_reach) begin
          state_d = S_RUN;
          retry_d = '0;
          loss_d  = '0;
        end else begin
          stable_d = stable_q + STB_W'(1);
        end
      end
      S_RUN: begin
        if (locked_s) begin
          loss_d = '0;
        end else if (loss_reach) begin
          state_d = S_RESET_PLL;
          tmr_d   = '0;
          if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
        end else begin
          loss_d = loss_q + LOSS_W'(1);
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RESET_PLL;
        tmr_d   = '0;
      end
    endcase

    pll_rst_d      = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    domain_ready_d = (state_d == S_RUN);
    lock_fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      sync_q         <= '0;
      state_q        <= S_RESET_PLL;
      tmr_q          <= '0;
      stable_q       <= '0;
      loss_q         <= '0;
      retry_q        <= '0;
      loss_cnt_q     <= '0;
      pll_rst_q      <= 1'b1;
      domain_ready_q <= 1'b0;
      lock_fail_q    <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      stable_q       <= stable_d;
      loss_q         <= loss_d;
      retry_q        <= retry_d;
      loss_cnt_q     <= loss_cnt_d;
      pll_rst_q      <= pll_rst_d;
      domain_ready_q <= domain_ready_d;
      lock_fail_q    <= lock_fail_d;
    end
  end

  assign sup.pll_rst      = pll_rst_q;
  assign sup.domain_ready = domain_ready_q;
  assign sup.lock_fail    = lock_fail_q;
  assign sup.retry_count  = retry_q;
  assign sup.loss_count   = loss_cnt_q;

endmodule

// File: tb/tb_cart_clk_supervisor.sv
// Directed bench for cart_clk_supervisor: timestamp-based reference model checked
// every cycle, plus hand-computed edge-exact expectations for each scenario.
module tb_cart_clk_supervisor;
  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int LOSS_FILTER   = 3;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_FAIL = 4;

  logic clk_74a;
  logic reset_n;
  int   tests;
  int   fails;

  cart_clk_supervisor_if sif ();

  cart_clk_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .LOSS_FILTER  (LOSS_FILTER)
  ) dut (
    .clk_74a(clk_74a),
    .reset_n(reset_n),
    .sup    (sif)
  );

  initial begin
    clk_74a = 1'b0;
    forever #5 clk_74a = ~clk_74a;
  end

  // Reference model: phases with absolute-edge timestamps instead of counters.
  int ph;
  int ph_start;
  int hi_since;
  int last_hi;
  int edge_n;
  int m_retry;
  int m_loss;
  int m_ls;
  int m_s1;
  bit model_ok;

  initial begin
    edge_n   = 0;
    model_ok = 1'b0;
    ph = PH_RST; ph_start = 0; hi_since = 0; last_hi = 0;
    m_retry = 0; m_loss = 0; m_ls = 0; m_s1 = 0;
    forever begin
      @(posedge clk_74a);
      edge_n++;
      if (!reset_n) begin
        ph = PH_RST; ph_start = edge_n;
        m_retry = 0; m_loss = 0; m_ls = 0; m_s1 = 0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        case (ph)
          PH_RST: if (edge_n == ph_start + RST_CYCLES) begin
            ph = PH_WAIT; ph_start = edge_n;
          end
          PH_WAIT: begin
            if (m_ls != 0) begin
              ph = PH_STAB; hi_since = edge_n - 1;
            end else if (edge_n == ph_start + LOCK_TIMEOUT) begin
              if (m_retry == MAX_RETRIES) ph = PH_FAIL;
              else begin
                m_retry++; ph = PH_RST; ph_start = edge_n;
              end
            end
          end
          PH_STAB: begin
            if (m_ls == 0) begin
              ph = PH_WAIT; ph_start = edge_n;
            end else if (edge_n >= hi_since + STABLE_CYCLES) begin
              ph = PH_RUN; m_retry = 0; last_hi = edge_n;
            end
          end
          PH_RUN: begin
            if (m_ls != 0) last_hi = edge_n;
            else if (edge_n - last_hi >= LOSS_FILTER) begin
              ph = PH_RST; ph_start = edge_n;
              if (m_loss < 255) m_loss++;
            end
          end
          default: ph = PH_FAIL;
        endcase
        m_ls = m_s1;
        m_s1 = int'(sif.pll_locked);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_74a);
      if (model_ok) begin
        int e_rst, e_rdy, e_fail;
        e_rst  = (ph == PH_RST || ph == PH_FAIL) ? 1 : 0;
        e_rdy  = (ph == PH_RUN) ? 1 : 0;
        e_fail = (ph == PH_FAIL) ? 1 : 0;
        tests++;
        if (int'(sif.pll_rst) != e_rst || int'(sif.domain_ready) != e_rdy ||
            int'(sif.lock_fail) != e_fail || int'(sif.retry_count) != m_retry ||
            int'(sif.loss_count) != m_loss) begin
          fails++;
          $display("FAIL model_cmp @%0t: got rst=%0d rdy=%0d fail=%0d retry=%0d loss=%0d, expected rst=%0d rdy=%0d fail=%0d retry=%0d loss=%0d",
                   $time, sif.pll_rst, sif.domain_ready, sif.lock_fail, sif.retry_count,
                   sif.loss_count, e_rst, e_rdy, e_fail, m_retry, m_loss);
        end
      end
    end
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk_74a);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sif.pll_locked = 1'b0;
    go(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!sif.domain_ready && k < 400) begin
      go(1);
      k++;
    end
    chk(nm, int'(sif.domain_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    sif.pll_locked = 1'b0;

    // 1: reset state and nominal lock
    go(3);
    chk("rst_pll_rst", int'(sif.pll_rst), 1);
    chk("rst_ready", int'(sif.domain_ready), 0);
    chk("rst_lock_fail", int'(sif.lock_fail), 0);
    chk("rst_retry", int'(sif.retry_count), 0);
    chk("rst_loss", int'(sif.loss_count), 0);
    reset_n = 1'b1;
    go(3);  chk("t1_rst_hold", int'(sif.pll_rst), 1);
    go(1);  chk("t1_rst_fall", int'(sif.pll_rst), 0);
    go(10); sif.pll_locked = 1'b1;
    go(9);  chk("t1_not_ready_e23", int'(sif.domain_ready), 0);
    go(1);  chk("t1_ready_e24", int'(sif.domain_ready), 1);
    chk("t1_retry", int'(sif.retry_count), 0);

    // 2: one-cycle dropout during stabilization restarts qualification
    do_reset();
    go(4);  sif.pll_locked = 1'b1;
    go(5);  sif.pll_locked = 1'b0;
    go(1);  sif.pll_locked = 1'b1;
    go(8);  chk("t2_low_8_after_relock", int'(sif.domain_ready), 0);
    go(1);  chk("t2_low_e19", int'(sif.domain_ready), 0);
    go(1);  chk("t2_ready_e20", int'(sif.domain_ready), 1);
    chk("t2_retry", int'(sif.retry_count), 0);

    // 3: one timeout, second reset pulse, then lock
    do_reset();
    go(4);  chk("t3_rst_fall", int'(sif.pll_rst), 0);
    go(99); chk("t3_pre_timeout_rst", int'(sif.pll_rst), 0);
    chk("t3_pre_timeout_retry", int'(sif.retry_count), 0);
    go(1);  chk("t3_timeout_rst", int'(sif.pll_rst), 1);
    chk("t3_timeout_retry", int'(sif.retry_count), 1);
    go(3);  chk("t3_pulse_hold", int'(sif.pll_rst), 1);
    go(1);  chk("t3_pulse_fall", int'(sif.pll_rst), 0);
    sif.pll_locked = 1'b1;
    go(9);  chk("t3_not_ready", int'(sif.domain_ready), 0);
    go(1);  chk("t3_ready", int'(sif.domain_ready), 1);
    chk("t3_retry_cleared", int'(sif.retry_count), 0);

    // 4: retries exhausted
    do_reset();
    go(311);
    chk("t4_pre_fail", int'(sif.lock_fail), 0);
    chk("t4_pre_fail_retry", int'(sif.retry_count), 2);
    go(1);
    chk("t4_fail", int'(sif.lock_fail), 1);
    chk("t4_fail_rst", int'(sif.pll_rst), 1);
    chk("t4_fail_retry", int'(sif.retry_count), 2);
    chk("t4_fail_ready", int'(sif.domain_ready), 0);
    go(500); sif.pll_locked = 1'b1;
    go(500);
    chk("t4_still_fail", int'(sif.lock_fail), 1);
    chk("t4_still_rst", int'(sif.pll_rst), 1);
    sif.pll_locked = 1'b0;
    reset_n = 1'b0;
    go(1);
    chk("t4_reset_clears_fail", int'(sif.lock_fail), 0);
    chk("t4_reset_rst", int'(sif.pll_rst), 1);
    chk("t4_reset_retry", int'(sif.retry_count), 0);

    // 5: lock-loss filtering and saturation
    do_reset();
    sif.pll_locked = 1'b1;
    wait_ready("t5_initial_lock");
    sif.pll_locked = 1'b0;
    go(2);  sif.pll_locked = 1'b1;
    go(6);
    chk("t5_glitch_ready", int'(sif.domain_ready), 1);
    chk("t5_glitch_loss", int'(sif.loss_count), 0);
    sif.pll_locked = 1'b0;
    go(3);  sif.pll_locked = 1'b1;
    go(1);
    chk("t5_ready_e4", int'(sif.domain_ready), 1);
    chk("t5_rst_e4", int'(sif.pll_rst), 0);
    go(1);
    chk("t5_drop_e5", int'(sif.domain_ready), 0);
    chk("t5_rst_e5", int'(sif.pll_rst), 1);
    chk("t5_loss1", int'(sif.loss_count), 1);
    wait_ready("t5_relock");
    for (int i = 0; i < 299; i++) begin
      sif.pll_locked = 1'b0;
      go(3);  sif.pll_locked = 1'b1;
      go(2);
      wait_ready("t5_loop_relock");
    end
    chk("t5_loss_sat", int'(sif.loss_count), 255);

    // 6: reset while stabilizing, with nonzero retry and loss counts
    sif.pll_locked = 1'b0;
    go(113);
    chk("t6_retry1", int'(sif.retry_count), 1);
    chk("t6_rst_low", int'(sif.pll_rst), 0);
    chk("t6_loss_kept", int'(sif.loss_count), 255);
    sif.pll_locked = 1'b1;
    go(8);
    chk("t6_stab_not_ready", int'(sif.domain_ready), 0);
    reset_n = 1'b0;
    go(1);
    chk("t6_reset_rst", int'(sif.pll_rst), 1);
    chk("t6_reset_ready", int'(sif.domain_ready), 0);
    chk("t6_reset_retry", int'(sif.retry_count), 0);
    chk("t6_reset_loss", int'(sif.loss_count), 0);
    reset_n = 1'b1;
    go(3);  chk("t6_pulse_hold", int'(sif.pll_rst), 1);
    go(1);  chk("t6_pulse_fall", int'(sif.pll_rst), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cart_clk_supervisor.md
# cart_clk_supervisor

Supervises the cartridge-domain PLL from the 74.25 MHz reference domain. It drives the PLL reset, synchronizes and qualifies the PLL `locked` output, and retries lock with a timeout. It raises `domain_ready` only after lock has been continuously stable, and the cartridge-domain reset synchronizer and cart bus logic consume that signal. It also reports lock failures and lock-loss events to the core status registers.

## Interface
Parameters:
- `RST_CYCLES`, 16: length of the PLL reset pulse, in clk_74a cycles.
- `LOCK_TIMEOUT`, 742500: cycles to wait for lock after PLL reset release (10 ms).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before `domain_ready`.
- `MAX_RETRIES`, 3: number of lock retries allowed before declaring failure (1..15).
- `LOSS_FILTER`, 4: consecutive synchronized-unlocked cycles in RUN that count as lock loss (≥1).

Ports:
- `clk_74a`, in, 1: 74.25 MHz reference clock. This is the only clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `pll_locked`, in, 1: PLL lock output. Asynchronous to `clk_74a`.
- `pll_rst`, out, 1: active-high PLL reset.
- `domain_ready`, out, 1: high while the PLL is qualified as locked.
- `lock_fail`, out, 1: sticky; set when retries are exhausted.
- `retry_count`, out, 4: lock attempts that timed out since the last RUN entry.
- `loss_count`, out, 8: saturating count of lock-loss events since reset.

## Operation
- **Synchronizer:** `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. Synchronizer flops reset to 0.
- **Reset state:** while `reset_n`=0, the block enters RESET_PLL with all counters 0, `pll_rst`=1, `domain_ready`=0, `lock_fail`=0, `retry_count`=0, `loss_count`=0.
- **RESET_PLL:** `pll_rst`=1. The cycle counter counts RST_CYCLES cycles, then the block moves to WAIT_LOCK and clears the timer.
- **WAIT_LOCK:** `pll_rst`=0, and the timer increments each cycle.
  - If `locked_s`=1, go to STABILIZE with the stable counter at 1.
  - Else, if the timer reaches LOCK_TIMEOUT-1 and `retry_count`==MAX_RETRIES, go to FAIL.
  - Else, if the timer reaches LOCK_TIMEOUT-1, increment `retry_count` and go to RESET_PLL.
  - If lock arrives on the timeout cycle, lock wins.
- **STABILIZE:** `pll_rst`=0.
  - If `locked_s`=0, return to WAIT_LOCK with the timer cleared. `retry_count` is unchanged.
  - When the stable counter reaches STABLE_CYCLES, go to RUN, set `domain_ready`=1, and clear `retry_count`.
- **RUN:** `domain_ready`=1.
  - A loss counter counts consecutive `locked_s`=0 cycles and clears on any `locked_s`=1 cycle.
  - When it reaches LOSS_FILTER: clear `domain_ready`, increment `loss_count` (saturating at 255), and go to RESET_PLL.
  - Unlocked glitches shorter than LOSS_FILTER cycles are ignored and `domain_ready` stays 1.
- **FAIL:** terminal. `pll_rst`=1, `lock_fail`=1, `domain_ready`=0. Only `reset_n` exits FAIL.
- **Widths:**
  - Timer width is clog2(LOCK_TIMEOUT); it must not wrap before the compare.
  - Stable and loss counters stop incrementing at their thresholds and do not wrap.
  - `retry_count` never exceeds MAX_RETRIES.

## Timing
- All outputs are registered.
- **Reset release:** `pll_rst` stays 1 for exactly RST_CYCLES rising edges after the first edge with `reset_n`=1, then falls.
- **Lock latency:** a `pll_locked` rise is seen as `locked_s` 2 edges later. `domain_ready` rises STABLE_CYCLES edges after `locked_s` first goes high, provided `locked_s` stays high throughout.
- **Loss latency:** a `pll_locked` fall in RUN drops `domain_ready` exactly 2 + LOSS_FILTER edges later. `pll_rst` rises on the same edge.
- **Reset mid-operation:** `reset_n`=0 in any state takes effect at the next edge. `domain_ready` drops and `pll_rst` rises on that edge; the counters and `lock_fail` clear on that edge.
- **Level outputs:** `domain_ready` and `pll_rst` are never both 1. Outside FAIL, `lock_fail` is 0.

## Test plan
Use parameters RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2, LOSS_FILTER=3.
1. **Nominal lock:** release reset, then raise `pll_locked` 10 cycles after `pll_rst` falls → `pll_rst` falls at edge 4 and `domain_ready` rises at edge 4+10+2+8. `retry_count`=0.
2. **Unstable lock:** in STABILIZE, pulse `pll_locked` low for 1 cycle at stable count 5 → `domain_ready` is still low 8 cycles after the relock; it rises 8 cycles after `locked_s` returns high. `retry_count`=0.
3. **Timeout then success:** hold `pll_locked`=0 through one timeout → `retry_count`=1 and a second 4-cycle `pll_rst` pulse occurs. Then lock → `domain_ready`=1 and `retry_count` returns to 0.
4. **Exhaustion:** never lock → 3 timeouts occur, then `lock_fail`=1, `pll_rst`=1, `retry_count`=2. The block stays there for 1000 cycles. Assert `reset_n`=0 → `lock_fail`=0.
5. **Lock loss:** in RUN, a 2-cycle low on `pll_locked` → no change. A 3-cycle low → `domain_ready` drops exactly 5 edges after the fall, `loss_count`=1, and the block relocks. Repeat 300 times → `loss_count` saturates at 255.
6. **Reset during STABILIZE:** assert `reset_n`=0 at stable count 6 → on the next edge `pll_rst`=1 and all counts are 0. The full RST_CYCLES pulse is reissued after release.
